// File: rtl/mem_access_unit.sv
// Load/store initiator for a word-addressed data memory.
// Sub-word stores are done as read-modify-write; one response per accepted request.
module mem_access_unit #(
    parameter int unsigned ADDR_W          = 32,
    parameter bit          ERR_ON_MISALIGN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    input  logic [31:0]       mem_rdata
);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [2:0] {IDLE, RD, CAP, WR, DONE} state_t;

    state_t            state, state_next;
    logic [1:0]        off_q, off_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              err_q, err_d;

    logic              req_ready_d, resp_valid_d, resp_err_d, mem_we_d;
    logic [31:0]       resp_rdata_d, mem_wdata_d;
    logic [ADDR_W-1:0] mem_addr_d;

    logic              misalign, illegal;
    logic [1:0]        eff_off;
    logic [4:0]        shamt;
    logic [31:0]       lane, lane_mask, load_val, merged;

    // Request decode: error detection and effective lane offset (forced alignment when errors are off)
    always_comb begin
        misalign = ((req_size == SZ_HALF) && req_addr[0]) ||
                   ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
        illegal  = (req_size == SZ_ILL) || (ERR_ON_MISALIGN && misalign);
        case (req_size)
            SZ_BYTE: eff_off = req_addr[1:0];
            SZ_HALF: eff_off = {req_addr[1], 1'b0};
            default: eff_off = 2'b00;
        endcase
    end

    // Lane extraction for loads and lane merge for sub-word stores
    always_comb begin
        shamt     = {off_q, 3'b000};
        lane      = mem_rdata >> shamt;
        lane_mask = ((size_q == SZ_BYTE) ? 32'h0000_00FF : 32'h0000_FFFF) << shamt;
        merged    = (mem_rdata & ~lane_mask) | ((wdata_q << shamt) & lane_mask);
        case (size_q)
            SZ_BYTE: load_val = uns_q ? {24'd0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
            SZ_HALF: load_val = uns_q ? {16'd0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
            default: load_val = lane;
        endcase
    end

    // Next state and next values of all registered outputs
    always_comb begin
        state_next   = state;
        off_d        = off_q;
        we_d         = we_q;
        size_d       = size_q;
        uns_d        = uns_q;
        wdata_d      = wdata_q;
        err_d        = err_q;
        mem_addr_d   = mem_addr;
        mem_wdata_d  = mem_wdata;
        resp_rdata_d = resp_rdata;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    off_d      = eff_off;
                    we_d       = req_we;
                    size_d     = req_size;
                    uns_d      = req_unsigned;
                    wdata_d    = req_wdata;
                    err_d      = illegal;
                    mem_addr_d = {req_addr[ADDR_W-1:2], 2'b00};
                    if (illegal) begin
                        state_next = DONE;
                    end else if (req_we && (req_size == SZ_WORD)) begin
                        mem_wdata_d = req_wdata;
                        state_next  = WR;
                    end else begin
                        state_next = RD;
                    end
                end
            end
            RD:   state_next = CAP;
            CAP: begin
                if (we_q) begin
                    mem_wdata_d = merged;
                    state_next  = WR;
                end else begin
                    resp_rdata_d = load_val;
                    state_next   = DONE;
                end
            end
            WR:      state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase

        req_ready_d  = (state_next == IDLE);
        mem_we_d     = (state_next == WR);
        resp_valid_d = (state_next == DONE);
        resp_err_d   = (state_next == DONE) && err_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            off_q      <= 2'b00;
            we_q       <= 1'b0;
            size_q     <= 2'b00;
            uns_q      <= 1'b0;
            wdata_q    <= 32'd0;
            err_q      <= 1'b0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
            mem_addr   <= ADDR_W'(0);
            mem_wdata  <= 32'd0;
            mem_we     <= 1'b0;
        end else begin
            state      <= state_next;
            off_q      <= off_d;
            we_q       <= we_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
            req_ready  <= req_ready_d;
            resp_valid <= resp_valid_d;
            resp_rdata <= resp_rdata_d;
            resp_err   <= resp_err_d;
            mem_addr   <= mem_addr_d;
            mem_wdata  <= mem_wdata_d;
            mem_we     <= mem_we_d;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus randomized
// transactions checked against a word-array reference model.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        resp_valid, resp_err, mem_we;
    logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;

    mem_access_unit #(.ADDR_W(32), .ERR_ON_MISALIGN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Device memory (registered read, write-first) and a separate reference copy
    logic [31:0] dmem [0:255];
    logic [31:0] ref_mem [0:255];
    logic        poke_en = 1'b0;
    logic [7:0]  poke_idx;
    logic [31:0] poke_val;
    logic [31:0] last_rd;

    always @(posedge clk) begin
        if (poke_en) dmem[poke_idx] <= poke_val;
        else if (mem_we) dmem[mem_addr[9:2]] <= mem_wdata;
        mem_rdata <= mem_we ? mem_wdata : dmem[mem_addr[9:2]];
    end

    task automatic poke(input logic [31:0] a, input logic [31:0] v);
        @(negedge clk);
        poke_en = 1'b1; poke_idx = a[9:2]; poke_val = v;
        @(posedge clk); #1;
        poke_en = 1'b0;
        ref_mem[a[9:2]] = v;
    endtask

    // ---------------- reference model ----------------
    function automatic logic ref_err(input logic [31:0] a, input logic [1:0] sz);
        return (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input logic uns);
        logic [31:0] w, v;
        int off;
        w = ref_mem[a[9:2]];
        off = int'(a % 4);
        if (sz == 2'd0) begin
            v = (w >> (8 * off)) % 256;
            if (!uns && v >= 128) v = v - 32'd256;
        end else if (sz == 2'd1) begin
            v = (w >> (8 * off)) % 65536;
            if (!uns && v >= 32768) v = v - 32'd65536;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [31:0] ref_store_word(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
        logic [31:0] w, unit, old;
        int off;
        if (sz == 2'd2) return d;
        w = ref_mem[a[9:2]];
        off = int'(a % 4);
        unit = (sz == 2'd0) ? 32'd256 : 32'd65536;
        old = (w >> (8 * off)) % unit;
        return w - (old << (8 * off)) + ((d % unit) << (8 * off));
    endfunction

    function automatic int ref_latency(input logic [31:0] a, input logic [1:0] sz, input logic we);
        if (ref_err(a, sz)) return 1;
        if (we) return (sz == 2'd2) ? 2 : 4;
        return 3;
    endfunction

    // ---------------- driver: one transaction, reports what it observed ----------------
    task automatic do_req(input logic [31:0] a, input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] d, output int lat, output int wcnt,
                          output logic [31:0] waddr, output logic [31:0] wdat,
                          output logic [31:0] rdata, output logic err);
        @(negedge clk);
        req_addr = a; req_we = we; req_size = sz; req_unsigned = uns; req_wdata = d;
        req_valid = 1'b1;
        for (int k = 0; k < 20 && !req_ready; k++) @(negedge clk);
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0; wcnt = 0; waddr = '0; wdat = '0; rdata = '0; err = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (mem_we) begin wcnt++; waddr = mem_addr; wdat = mem_wdata; end
            if (resp_valid) begin lat = c; rdata = resp_rdata; err = resp_err; break; end
        end
    endtask

    int lat, wcnt;
    logic [31:0] waddr, wdat, rdata;
    logic err;

    task automatic test_reset;
        poke(32'h0C, 32'h1234_5678);
        do_req(32'h0C, 1'b0, 2'd2, 1'b0, 32'h0, lat, wcnt, waddr, wdat, rdata, err);
        do_req(32'h14, 1'b1, 2'd2, 1'b0, 32'hCAFE_F00D, lat, wcnt, waddr, wdat, rdata, err);
        ref_mem[5] = 32'hCAFE_F00D;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({req_ready, resp_valid, resp_err, mem_we} !== 4'b1000) begin
            errors++; $display("FAIL reset_flags got %b want 1000", {req_ready, resp_valid, resp_err, mem_we});
        end
        checks++;
        if (resp_rdata !== 32'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            errors++; $display("FAIL reset_data got rdata=%h addr=%h wdata=%h want 0", resp_rdata, mem_addr, mem_wdata);
        end
        @(negedge clk); rst = 1'b0;
        last_rd = 32'h0;
        do_req(32'h10, 1'b1, 2'd2, 1'b0, 32'hDEAD_BEEF, lat, wcnt, waddr, wdat, rdata, err);
        ref_mem[4] = 32'hDEAD_BEEF;
        checks++;
        if (wcnt !== 1 || waddr !== 32'h10 || wdat !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL reset_wstore got n=%0d addr=%h data=%h want 1/00000010/deadbeef", wcnt, waddr, wdat);
        end
        checks++;
        if (lat !== 2 || err !== 1'b0) begin
            errors++; $display("FAIL reset_wstore_lat got %0d err=%b want 2 err=0", lat, err);
        end
    endtask

    task automatic test_signed_load;
        logic [31:0] a_tab [3] = '{32'h23, 32'h23, 32'h22};
        logic [1:0]  s_tab [3] = '{2'd0, 2'd0, 2'd1};
        logic        u_tab [3] = '{1'b0, 1'b1, 1'b0};
        logic [31:0] e_tab [3] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF};
        poke(32'h20, 32'h80FF_7F01);
        for (int i = 0; i < 3; i++) begin
            do_req(a_tab[i], 1'b0, s_tab[i], u_tab[i], 32'h0, lat, wcnt, waddr, wdat, rdata, err);
            checks++;
            if (rdata !== e_tab[i] || rdata !== ref_load(a_tab[i], s_tab[i], u_tab[i])) begin
                errors++; $display("FAIL signed_load[%0d] got %h want %h", i, rdata, e_tab[i]);
            end
            checks++;
            if (lat !== 3 || wcnt !== 0) begin
                errors++; $display("FAIL signed_load_lat[%0d] got lat=%0d wr=%0d want 3/0", i, lat, wcnt);
            end
            last_rd = e_tab[i];
        end
    endtask

    task automatic test_subword_store;
        poke(32'h40, 32'h1122_3344);
        do_req(32'h41, 1'b1, 2'd0, 1'b0, 32'h0000_00AA, lat, wcnt, waddr, wdat, rdata, err);
        checks++;
        if (wcnt !== 1 || wdat !== 32'h1122_AA44 || waddr !== 32'h40 || lat !== 4) begin
            errors++; $display("FAIL sb got n=%0d data=%h addr=%h lat=%0d want 1/1122aa44/40/4", wcnt, wdat, waddr, lat);
        end
        ref_mem[16] = ref_store_word(32'h41, 2'd0, 32'hAA);
        do_req(32'h42, 1'b1, 2'd1, 1'b0, 32'h0000_BEEF, lat, wcnt, waddr, wdat, rdata, err);
        checks++;
        if (wcnt !== 1 || wdat !== 32'hBEEF_AA44 || lat !== 4) begin
            errors++; $display("FAIL sh got n=%0d data=%h lat=%0d want 1/beefaa44/4", wcnt, wdat, lat);
        end
        ref_mem[16] = ref_store_word(32'h42, 2'd1, 32'hBEEF);
        do_req(32'h40, 1'b0, 2'd2, 1'b0, 32'h0, lat, wcnt, waddr, wdat, rdata, err);
        checks++;
        if (rdata !== 32'hBEEF_AA44) begin
            errors++; $display("FAIL sub_lw got %h want beefaa44", rdata);
        end
        last_rd = 32'hBEEF_AA44;
    endtask

    task automatic test_errors;
        logic [31:0] a_tab [3] = '{32'h21, 32'h13, 32'h20};
        logic [1:0]  s_tab [3] = '{2'd2, 2'd1, 2'd3};
        logic        w_tab [3] = '{1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            do_req(a_tab[i], w_tab[i], s_tab[i], 1'b0, 32'h5555_AAAA, lat, wcnt, waddr, wdat, rdata, err);
            checks++;
            if (err !== 1'b1 || lat !== 1 || wcnt !== 0) begin
                errors++; $display("FAIL err[%0d] got err=%b lat=%0d wr=%0d want 1/1/0", i, err, lat, wcnt);
            end
            checks++;
            if (rdata !== last_rd) begin
                errors++; $display("FAIL err_rdata[%0d] got %h want %h", i, rdata, last_rd);
            end
        end
    endtask

    task automatic test_reset_mid;
        int bad_we = 0, bad_rv = 0;
        @(negedge clk);
        req_addr = 32'h41; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
        req_wdata = 32'h77; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk); @(negedge clk);   // second cycle after accept is the capture cycle
        rst = 1'b1;
        #1;
        if (mem_we) bad_we++;
        if (resp_valid) bad_rv++;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            if (mem_we) bad_we++;
            if (resp_valid) bad_rv++;
        end
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL midrst_ready got %b want 1", req_ready);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (mem_we) bad_we++;
            if (resp_valid) bad_rv++;
        end
        checks++;
        if (bad_we != 0 || bad_rv != 0) begin
            errors++; $display("FAIL midrst_quiet got we=%0d rv=%0d want 0/0", bad_we, bad_rv);
        end
        last_rd = 32'h0;
        do_req(32'h40, 1'b0, 2'd2, 1'b0, 32'h0, lat, wcnt, waddr, wdat, rdata, err);
        checks++;
        if (rdata !== ref_load(32'h40, 2'd2, 1'b0) || lat !== 3) begin
            errors++; $display("FAIL midrst_lw got %h lat=%0d want %h lat=3", rdata, lat, ref_load(32'h40, 2'd2, 1'b0));
        end
        last_rd = ref_load(32'h40, 2'd2, 1'b0);
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp_q[$];
        logic [31:0] alt [2] = '{32'h20, 32'h40};
        int sel = 0, accepts = 0, resps = 0, bad = 0;
        logic rdy;
        @(negedge clk);
        req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = alt[0]; req_valid = 1'b1;
        for (int c = 0; c < 22; c++) begin
            if (c == 10) req_valid = 1'b0;
            if (resp_valid) begin
                resps++;
                if (exp_q.size() == 0) bad++;
                else begin
                    last_rd = exp_q.pop_front();
                    if (resp_rdata !== last_rd) bad++;
                end
            end
            rdy = req_ready && req_valid;
            @(negedge clk);
            if (rdy) begin
                accepts++;
                exp_q.push_back(ref_load(req_addr, 2'd2, 1'b0));
                sel = 1 - sel;
                req_addr = alt[sel];
            end
        end
        checks++;
        if (accepts != 3 || resps != 3) begin
            errors++; $display("FAIL b2b_count got acc=%0d resp=%0d want 3/3", accepts, resps);
        end
        checks++;
        if (bad != 0 || exp_q.size() != 0) begin
            errors++; $display("FAIL b2b_data got bad=%0d left=%0d want 0/0", bad, exp_q.size());
        end
    endtask

    task automatic test_random;
        logic [31:0] a, d, exp_w;
        logic [1:0] sz;
        logic we, uns, e;
        for (int n = 0; n < 60; n++) begin
            a = 32'($urandom_range(0, 1023));
            sz = 2'($urandom_range(0, 3));
            we = 1'($urandom_range(0, 1));
            uns = 1'($urandom_range(0, 1));
            d = $urandom;
            if (n % 3 != 0) begin
                if (sz == 2'd1) a = a & ~32'd1;
                if (sz == 2'd2) a = a & ~32'd3;
            end
            e = ref_err(a, sz);
            exp_w = ref_store_word(a, sz, d);
            do_req(a, we, sz, uns, d, lat, wcnt, waddr, wdat, rdata, err);
            checks++;
            if (err !== e || lat !== ref_latency(a, sz, we)) begin
                errors++; $display("FAIL rnd_resp[%0d] a=%h sz=%0d we=%b got err=%b lat=%0d want %b/%0d", n, a, sz, we, err, lat, e, ref_latency(a, sz, we));
            end
            if (!e && we) begin
                checks++;
                if (wcnt !== 1 || waddr !== {a[31:2], 2'b00} || wdat !== exp_w) begin
                    errors++; $display("FAIL rnd_store[%0d] got n=%0d addr=%h data=%h want 1/%h/%h", n, wcnt, waddr, wdat, {a[31:2], 2'b00}, exp_w);
                end
                ref_mem[a[9:2]] = exp_w;
            end else begin
                checks++;
                if (wcnt !== 0) begin
                    errors++; $display("FAIL rnd_nowrite[%0d] got %0d writes want 0", n, wcnt);
                end
                if (!e) last_rd = ref_load(a, sz, uns);
            end
            checks++;
            if (rdata !== last_rd) begin
                errors++; $display("FAIL rnd_rdata[%0d] got %h want %h", n, rdata, last_rd);
            end
            @(negedge clk);
            checks++;
            if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
                errors++; $display("FAIL rnd_pulse[%0d] got rv=%b rdy=%b want 0/1", n, resp_valid, req_ready);
            end
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_we = 1'b0;
        req_size = 2'd0; req_unsigned = 1'b0; req_wdata = '0; last_rd = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 256; i++) poke(32'(i * 4), $urandom);
        test_reset();
        test_signed_load();
        test_subword_store();
        test_errors();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator for the word-addressed data memory: takes byte/halfword/word load and store requests from the CPU datapath and drives the memory's address, write-data and write-enable ports.
- Sub-word stores use read-modify-write, since the memory only writes whole words.
- Sits between the EX/MEM datapath and the data memory, and returns one response per accepted request.

Parameters:
- ADDR_W, 32, width of request and memory byte addresses.
- ERR_ON_MISALIGN, 1: 1 = misaligned request returns an error with no memory access; 0 = low address bits are forced to alignment and the access proceeds.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; asynchronous, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  unit idle, request accepted this cycle if req_valid=1.
- req_addr  input  ADDR_W  byte address.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  input  1  loads: 1 = zero-extend, 0 = sign-extend.
- req_wdata  input  32  store data, right-aligned.
- resp_valid  output  1  one-cycle completion pulse.
- resp_rdata  output  32  load result, held until next resp_valid.
- resp_err  output  1  error flag, valid with resp_valid.
- mem_addr  output  ADDR_W  word-aligned byte address {addr[ADDR_W-1:2],2'b00}.
- mem_wdata  output  32  word to write.
- mem_we  output  1  memory write enable.
- mem_rdata  input  32  memory output; registered by memory on clk; valid the cycle after the address is presented; after a write edge it equals the written word.

Behaviour:
- Reset (async, rst=1): state IDLE; outputs forced immediately, independent of clk:
  - req_ready=1; resp_valid=0; resp_rdata=0; resp_err=0;
  - mem_addr=0; mem_wdata=0; mem_we=0.
- Reset mid-operation:
  - Any in-flight request is dropped with no response.
  - mem_we deasserts combinationally with rst.
- States: IDLE, RD, CAP, WR, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid at the clock edge: latch addr, we, size, unsigned, wdata.
  - Next state:
    - size=11, or misaligned (half with addr[0]=1; word with addr[1:0]!=0) while ERR_ON_MISALIGN=1 -> DONE with err=1.
    - Store word -> WR.
    - Otherwise -> RD.
- RD:
  - mem_addr = latched word address; mem_we=0.
  - Next state -> CAP.
- CAP:
  - mem_rdata is valid in this cycle.
  - Load: extract lane by offset (little-endian; byte k = bits 8k+7:8k; half at offset 0 or 2), extend per req_unsigned, register into resp_rdata. Next state -> DONE.
  - Sub-word store: merge wdata[7:0] or wdata[15:0] into the read word at the addressed lane, other lanes unchanged; register as the write word. Next state -> WR.
- WR:
  - mem_addr held; mem_wdata = write word; mem_we=1 for exactly this cycle.
  - Next state -> DONE.
- DONE:
  - resp_valid=1 for one cycle; resp_err per latched condition; req_ready=0.
  - Next state -> IDLE.
  - Stores and errors leave resp_rdata unchanged.
- Latency, accept edge to resp_valid high:
  - load: 3 cycles;
  - sub-word store: 4 cycles;
  - word store: 2 cycles;
  - error: 1 cycle.
- Back-to-back:
  - A new request is accepted only in IDLE; no acceptance in DONE, so one idle cycle separates consecutive transactions.
  - req_valid held while req_ready=0 is ignored; the request is accepted only once req_ready is 1 again.
- mem_we is 0 in every state except WR; no memory write ever occurs on an error path.
- ERR_ON_MISALIGN=0: half uses addr[1]; word ignores addr[1:0].

Test Plan:
- Reset: assert rst between edges -> all outputs 0 and req_ready=1 immediately; a later word store to 0x10 of 0xDEADBEEF -> mem_we high in exactly one cycle with mem_addr=0x10; resp_valid 2 cycles after accept.
- Signed load: memory word at 0x20 = 0x80FF7F01; lb from 0x23 -> resp_rdata=0xFFFFFF80; lbu from 0x23 -> 0x00000080; lh from 0x22 -> 0xFFFF80FF; each resp_valid 3 cycles after accept.
- Sub-word store: word at 0x40 = 0x11223344; sb 0xAA to 0x41 -> mem_wdata=0x1122AA44; sh 0xBEEF to 0x42 -> mem_wdata=0xBEEFAA44; lw 0x40 then returns 0xBEEFAA44.
- Errors (ERR_ON_MISALIGN=1): lw 0x21, sh 0x13, size=11 -> resp_valid with resp_err=1 one cycle after accept; mem_we never asserts; resp_rdata unchanged.
- Reset mid sub-word store: assert rst while in CAP -> mem_we stays 0; no resp_valid; req_ready=1 once rst falls; the next lw completes normally.
- Handshake: req_valid held high for 10 cycles with alternating lw requests -> accepts only in IDLE cycles, one resp_valid per accept, no request lost or duplicated.
